iterative_comparator: RTL and testbench
=======================================

# iterative_comparator

Parametrised, multi-cycle magnitude comparator succeeding the fixed 8-bit parallel comparator. It latches two WIDTH-bit operands on a start request and scans them MSB-first, DIGIT bits per clock. It stops at the first differing digit and reports greater/less/equal with a one-cycle done pulse. Signed or unsigned comparison is selected per operation. It serves as the area-reduced comparator for wide operands where a single-cycle parallel tree is too costly.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0 (elaboration-time check, fatal on violation).
- NDIG (localparam), WIDTH/DIGIT: digits per operand.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; accepted only when busy=0.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- busy  out  1  comparison in progress.
- done  out  1  single-cycle pulse; g/l/eq updated in this cycle.
- g  out  1  A > B (last completed operation).
- l  out  1  A < B (last completed operation).
- eq  out  1  A == B (last completed operation).

## Operation
- FSM states: IDLE, RUN.
- IDLE: on start=1 latch A, B and signed_mode, clear digit counter, go to RUN.
- Signed mode: invert the MSB of both latched operands at capture, then compare unsigned. Unsigned mode uses the operands unchanged.
- RUN: compare digit index i (bits WIDTH-1-i·DIGIT down to WIDTH-(i+1)·DIGIT) of A against B.
  - Digits differ: write g/l from that digit (eq=0), pulse done, go to IDLE.
  - Digits equal and i == NDIG-1: write eq=1, g=l=0, pulse done, go to IDLE.
  - Otherwise: increment i and stay in RUN.
- Exactly one of g/l/eq is 1 after any completed operation.
- Results hold until the next done. They do not clear on start.
- start while busy=1 is ignored. No queueing, no error flag.
- Changes on A/B/signed_mode while busy are ignored (latched copies are used).
- Digit counter width: max(1, $clog2(NDIG)).
- DIGIT == WIDTH degenerates to a single RUN cycle.

## Timing
- Reset: state=IDLE, busy=0, done=0, g=0, l=0, eq=0, counter=0. Operand registers don't-care.
- rst asserted mid-RUN aborts the operation. Outputs take reset values on the next cycle and no done is issued.
- rst has priority over start in the same cycle.
- start high in cycle 0 with busy=0: busy=1 in cycles 1..k, and done=1 with results valid in cycle k+1. k is the number of digits examined (1..NDIG).
- busy=0 in the done cycle. A start in that cycle is accepted, giving back-to-back operations with one-cycle spacing.
- Latency: min 2 cycles (first digit differs), max NDIG+1 cycles (equal, or difference in last digit).
- done is never high for two consecutive cycles from one operation.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=2, unsigned, A=255, B=0, start in cycle 0 -> done in cycle 2, g=1, l=0, eq=0. busy high in cycle 1 only.
- WIDTH=8, DIGIT=2: A=144, B=88 -> g=1, done in cycle 2. A=88, B=88 -> eq=1, done in cycle 5. A=0, B=1 -> l=1, done in cycle 5.
- Signed mode, A=8'h80, B=8'h01 -> l=1 in cycle 2. Same operands unsigned -> g=1. Signed A=8'hFF, B=8'hFE -> g=1 after 4 digits.
- Start re-asserted during busy with different operands -> ignored, original result reported. Start in the done cycle -> second operation accepted, second done exactly k+1 cycles later.
- rst pulsed in cycle 2 of an A=B compare -> busy=0, g=l=eq=0 next cycle, no done. A fresh start afterwards completes normally.
- Parameter sweep WIDTH∈{8,16,32}, DIGIT∈{1,4,WIDTH}, 1000 random signed/unsigned pairs each:
  - g/l/eq match the reference relational result.
  - done latency equals first-differing-digit index + 2, capped at NDIG+1.

Source files
------------

// File: rtl/iterative_comparator.sv
// Multi-cycle magnitude comparator: latches two operands and scans them MSB-first,
// DIGIT bits per clock, stopping at the first differing digit.
module iterative_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             eq
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_chk
    $fatal(1, "iterative_comparator: illegal WIDTH/DIGIT combination");
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v, input logic sm);
    return v ^ {sm, {(WIDTH-1){1'b0}}};
  endfunction

  function automatic logic [DIGIT-1:0] top_digit(input logic [WIDTH-1:0] v);
    return v[WIDTH-1 -: DIGIT];
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             done_q, done_d;
  logic             g_q, g_d;
  logic             l_q, l_d;
  logic             eq_q, eq_d;
  logic [DIGIT-1:0] a_dig, b_dig;

  assign a_dig = top_digit(a_q);
  assign b_dig = top_digit(b_q);

  // Operands are shifted left each step so the digit under test is always at the top.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    g_d     = g_q;
    l_d     = l_q;
    eq_d    = eq_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = order_key(A, signed_mode);
          b_d     = order_key(B, signed_mode);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (a_dig != b_dig) begin
          g_d     = (a_dig > b_dig);
          l_d     = (a_dig < b_dig);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == LAST_DIG) begin
          g_d     = 1'b0;
          l_d     = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      g_q     <= g_d;
      l_q     <= l_d;
      eq_q    <= eq_d;
    end
  end

  // Operand registers carry no reset; their content only matters while in RUN.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign g    = g_q;
  assign l    = l_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_iterative_comparator.sv
// Bench for iterative_comparator: directed 8/2 cases plus a randomized sweep of
// several WIDTH/DIGIT configurations against a behavioural model.
module tb_iterative_comparator;

  localparam int NCFG = 10;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   sweeps_finished = 0;

  logic       d_rst, d_start, d_sm;
  logic [7:0] d_a, d_b;
  logic       d_busy, d_done, d_g, d_l, d_eq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_w(input int i);
    case (i)
      0, 1, 2, 3: return 8;
      4, 5, 6:    return 16;
      default:    return 32;
    endcase
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 4;
      3: return 8;
      4: return 1;
      5: return 4;
      6: return 16;
      7: return 1;
      8: return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] msk(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

  // Relational result from plain integer arithmetic: 1 = greater, -1 = less, 0 = equal.
  function automatic int ref_rel(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b);
    longint va, vb;
    va = longint'(a & msk(w));
    vb = longint'(b & msk(w));
    if (sm && a[w-1]) va = va - (longint'(1) << w);
    if (sm && b[w-1]) vb = vb - (longint'(1) << w);
    if (va > vb) return 1;
    if (va < vb) return -1;
    return 0;
  endfunction

  // Number of digits examined: index of first differing digit + 1, or all digits.
  function automatic int ref_digits(input int w, input int d, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, dm;
    x  = {32'd0, (a ^ b) & msk(w)};
    dm = (64'd1 << d) - 64'd1;
    for (int i = 0; i < w / d; i++) begin
      if (((x >> (w - (i + 1) * d)) & dm) != 64'd0) return i + 1;
    end
    return w / d;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = cfg_w(gi);
    localparam int D = cfg_d(gi);

    logic         st, sm, rs;
    logic [W-1:0] av, bv;
    logic         busy, done, g, l, eq;

    iterative_comparator #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk        (clk),
      .rst        (rs),
      .start      (st),
      .signed_mode(sm),
      .A          (av),
      .B          (bv),
      .busy       (busy),
      .done       (done),
      .g          (g),
      .l          (l),
      .eq         (eq)
    );

    bit m_valid, m_busy, m_done, m_g, m_l, m_eq;
    int m_left = 0;
    int p_rel  = 0;

    always @(posedge clk) begin
      if (rs) begin
        m_valid <= 1'b1;
        m_busy  <= 1'b0;
        m_done  <= 1'b0;
        m_left  <= 0;
        m_g     <= 1'b0;
        m_l     <= 1'b0;
        m_eq    <= 1'b0;
      end else begin
        m_done <= 1'b0;
        if (m_left > 0) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_g    <= (p_rel > 0);
            m_l    <= (p_rel < 0);
            m_eq   <= (p_rel == 0);
          end
        end else if (st) begin
          p_rel  <= ref_rel(W, sm, 32'(av), 32'(bv));
          m_left <= ref_digits(W, D, 32'(av), 32'(bv));
          m_busy <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (m_valid)
        chk({busy, done, g, l, eq} === {m_busy, m_done, m_g, m_l, m_eq},
            $sformatf("cfg%0d_w%0d_d%0d_outs", gi, W, D),
            64'({busy, done, g, l, eq}), 64'({m_busy, m_done, m_g, m_l, m_eq}));
    end

    if (gi == 0) begin : g_dir
      assign st     = d_start;
      assign sm     = d_sm;
      assign rs     = d_rst;
      assign av     = d_a;
      assign bv     = d_b;
      assign d_busy = busy;
      assign d_done = done;
      assign d_g    = g;
      assign d_l    = l;
      assign d_eq   = eq;
    end else begin : g_rnd
      initial begin
        logic [31:0] r, t;
        int p, cyc, mode;
        rs = 1'b1; st = 1'b0; sm = 1'b0; av = '0; bv = '0;
        repeat (2) @(negedge clk);
        rs = 1'b0;
        for (int n = 0; n < 1000; n++) begin
          r = $urandom; av = r[W-1:0];
          mode = $urandom_range(0, 2);
          if (mode == 0) begin
            r = $urandom; bv = r[W-1:0];
          end else if (mode == 1) begin
            bv = av;
          end else begin
            p = $urandom_range(0, W - 1);
            r = $urandom;
            t = 32'(av) ^ ((r & ((32'd1 << p) - 32'd1)) | (32'd1 << p));
            bv = t[W-1:0];
          end
          sm = 1'($urandom_range(0, 1));
          st = 1'b1;
          @(negedge clk);
          cyc = 1;
          while (!done && cyc < W + 4) begin
            st = ($urandom_range(0, 3) == 0);
            r = $urandom; av = r[W-1:0];
            @(negedge clk);
            cyc++;
          end
          st = 1'b0;
          if (!done) begin
            chk(1'b0, $sformatf("cfg%0d_done_timeout", gi), 64'(cyc), 64'(W + 1));
            rs = 1'b1;
            @(negedge clk);
            rs = 1'b0;
          end
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        sweeps_finished++;
      end
    end
  end

  // Starts at the current negedge (cycle 0); returns at the negedge of the done cycle.
  task automatic op0(input logic [7:0] a, input logic [7:0] b, input bit sm, input int lat,
                     input bit eg, input bit el, input bit ee, input int junk, input string nm);
    int cyc;
    d_a = a; d_b = b; d_sm = sm; d_start = 1'b1;
    @(negedge clk);
    cyc = 1;
    d_start = 1'b0;
    while (d_done !== 1'b1 && cyc < 20) begin
      chk(d_busy === 1'b1, {nm, "_busy"}, 64'(d_busy), 64'd1);
      d_start = (cyc == junk);
      d_a = 8'($urandom);
      d_b = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    d_start = 1'b0;
    chk(cyc == lat, {nm, "_latency"}, 64'(cyc), 64'(lat));
    chk({d_g, d_l, d_eq} === {eg, el, ee}, {nm, "_gle"}, 64'({d_g, d_l, d_eq}), 64'({eg, el, ee}));
    chk(d_busy === 1'b0, {nm, "_busy_in_done"}, 64'(d_busy), 64'd0);
  endtask

  initial begin
    d_rst = 1'b1; d_start = 1'b0; d_sm = 1'b0; d_a = '0; d_b = '0;
    repeat (3) @(negedge clk);
    chk({d_busy, d_done, d_g, d_l, d_eq} === 5'b0, "reset_state",
        64'({d_busy, d_done, d_g, d_l, d_eq}), 64'd0);
    d_rst = 1'b0;
    @(negedge clk);

    op0(8'd255, 8'd0,   1'b0, 2, 1'b1, 1'b0, 1'b0, -1, "u255_0");
    op0(8'd144, 8'd88,  1'b0, 2, 1'b1, 1'b0, 1'b0, -1, "u144_88");
    op0(8'd88,  8'd88,  1'b0, 5, 1'b0, 1'b0, 1'b1, -1, "u88_88");
    op0(8'd0,   8'd1,   1'b0, 5, 1'b0, 1'b1, 1'b0, -1, "u0_1");
    op0(8'h80,  8'h01,  1'b1, 2, 1'b0, 1'b1, 1'b0, -1, "s80_01");
    op0(8'h80,  8'h01,  1'b0, 2, 1'b1, 1'b0, 1'b0, -1, "u80_01");
    op0(8'hFF,  8'hFE,  1'b1, 5, 1'b1, 1'b0, 1'b0, -1, "sFF_FE");
    op0(8'd88,  8'd88,  1'b0, 5, 1'b0, 1'b0, 1'b1,  2, "start_while_busy");
    @(negedge clk);

    d_a = 8'd88; d_b = 8'd88; d_sm = 1'b0; d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    chk({d_busy, d_done, d_g, d_l, d_eq} === 5'b0, "abort_state",
        64'({d_busy, d_done, d_g, d_l, d_eq}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk({d_busy, d_done} === 2'b00, "abort_no_done", 64'({d_busy, d_done}), 64'd0);
    end
    op0(8'd0, 8'd1, 1'b0, 5, 1'b0, 1'b1, 1'b0, -1, "after_abort");

    for (int c = 0; c < 90000 && sweeps_finished < NCFG - 1; c++) @(negedge clk);
    chk(sweeps_finished == NCFG - 1, "sweep_complete", 64'(sweeps_finished), 64'(NCFG - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
